data_memory_io: RTL and testbench

//  Data-side memory stage directly downstream of the single-cycle processor core.

---
 rtl/data_memory_io.sv | 76 +++++++
 tb/tb_data_memory_io.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/data_memory_io.sv
// data_memory_io: word RAM plus memory-mapped LED, switch, timer and status registers behind a single-cycle core
module data_memory_io #(
  parameter int          OPERAND_LENGTH = 31,
  parameter int          DEPTH_WORDS    = 256,
  parameter logic [31:0] IO_BASE        = 32'h1000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [OPERAND_LENGTH:0] memAddress,
  input  logic [OPERAND_LENGTH:0] writeDataMem,
  input  logic                  memRead,
  input  logic                  memWrite,
  output logic [OPERAND_LENGTH:0] readDataMem,
  input  logic [15:0]           switches,
  output logic [15:0]           leds,
  output logic                  timerIrq
);
  localparam int W = OPERAND_LENGTH + 1;
  localparam int AW = $clog2(DEPTH_WORDS);
  localparam logic [W-1:0] RAM_BYTES = W'(DEPTH_WORDS * 4);
  localparam logic [W-1:0] LED_ADDR = W'(IO_BASE);
  localparam logic [W-1:0] SW_ADDR = W'(IO_BASE + 32'h4);
  localparam logic [W-1:0] COUNT_ADDR = W'(IO_BASE + 32'h8);
  localparam logic [W-1:0] CMP_ADDR = W'(IO_BASE + 32'hC);
  localparam logic [W-1:0] STATUS_ADDR = W'(IO_BASE + 32'h10);
  logic [W-1:0] ram [DEPTH_WORDS];
  logic [15:0] ledReg, swMeta, swSync;
  logic [W-1:0] count, cmp;
  logic [2:0] status, statusSet, statusClr;
  logic [AW-1:0] wordIdx;
  logic access, aligned, isRam, isLed, isSw, isCount, isCmp, isStatus, unmapped, misaligned, timerHit;
  always_comb begin
    access = memRead | memWrite;
    aligned = memAddress[1:0] == 2'b00;
    wordIdx = memAddress[AW+1:2];
    isRam = aligned && memAddress < RAM_BYTES;
    isLed = aligned && memAddress == LED_ADDR;
    isSw = aligned && memAddress == SW_ADDR;
    isCount = aligned && memAddress == COUNT_ADDR;
    isCmp = aligned && memAddress == CMP_ADDR;
    isStatus = aligned && memAddress == STATUS_ADDR;
    misaligned = access && !aligned;
    unmapped = access && aligned && !(isRam || isLed || isSw || isCount || isCmp || isStatus);
    timerHit = cmp != '0 && count == cmp;
    statusSet = {unmapped, misaligned, timerHit};
    statusClr = (memWrite && isStatus) ? writeDataMem[2:0] : 3'b000;
    readDataMem = !memRead ? '0 :
                  isRam    ? ram[wordIdx] :
                  isLed    ? W'(ledReg) :
                  isSw     ? W'(swSync) :
                  isCount  ? count :
                  isCmp    ? cmp :
                  isStatus ? W'(status) : '0;
  end
  // RAM shares the reset process so a store coinciding with reset is dropped; its contents are never cleared
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ledReg <= '0;
      swMeta <= '0;
      swSync <= '0;
      count <= '0;
      cmp <= '0;
      status <= '0;
    end else begin
      swMeta <= switches;
      swSync <= swMeta;
      count <= (memWrite && isCount) ? '0 : count + W'(1);
      status <= (status & ~statusClr) | statusSet;
      if (memWrite && isLed) ledReg <= writeDataMem[15:0];
      if (memWrite && isCmp) cmp <= writeDataMem;
      if (memWrite && isRam) ram[wordIdx] <= writeDataMem;
    end
  end
  assign leds = ledReg;
  assign timerIrq = status[0];
endmodule

// File: tb/tb_data_memory_io.sv
// tb_data_memory_io: directed spec scenarios plus random traffic against an address-map reference model
module tb_data_memory_io;
  localparam logic [31:0] IOB = 32'h1000;
  logic clk = 1'b0, rst = 1'b0;
  logic [31:0] memAddress = '0, writeDataMem = '0, readDataMem;
  logic memRead = 1'b0, memWrite = 1'b0, timerIrq;
  logic [15:0] switches = '0, leds;
  int nVec = 0, nBad = 0;
  logic [31:0] mem [int];
  bit [15:0] mLed, swHist[$];
  bit [31:0] mCount, mCmp;
  bit [2:0] mStatus;

  data_memory_io dut (
    .clk(clk), .rst(rst), .memAddress(memAddress), .writeDataMem(writeDataMem),
    .memRead(memRead), .memWrite(memWrite), .readDataMem(readDataMem),
    .switches(switches), .leds(leds), .timerIrq(timerIrq)
  );

  always #5 clk = ~clk;

  task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nVec++;
    if (got !== exp) begin
      nBad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic modelReset();
    mLed = 0; mCount = 0; mCmp = 0; mStatus = 0;
    swHist = {16'h0, 16'h0};
  endtask

  function automatic bit expRead(input logic [31:0] a, output logic [31:0] v);
    v = 0;
    if (a[1:0] != 2'b00) return 1;
    if (a < 32'h400) begin
      if (!mem.exists(int'(a >> 2))) return 0;
      v = mem[int'(a >> 2)];
      return 1;
    end
    case (a)
      IOB:          v = {16'h0, mLed};
      IOB + 32'h4:  v = {16'h0, swHist[swHist.size() - 2]};
      IOB + 32'h8:  v = mCount;
      IOB + 32'hC:  v = mCmp;
      IOB + 32'h10: v = {29'h0, mStatus};
      default:      v = 0;
    endcase
    return 1;
  endfunction

  task automatic modelEdge(input logic [31:0] a, input logic [31:0] wd, input bit rd, input bit wr);
    bit [2:0] setB, clrB;
    bit cleared;
    setB = 0; clrB = 0; cleared = 0;
    setB[0] = mCmp != 0 && mCount == mCmp;
    if ((rd || wr) && a[1:0] != 2'b00) setB[1] = 1;
    else if ((rd || wr) && !(a < 32'h400 || a inside {IOB, IOB + 32'h4, IOB + 32'h8, IOB + 32'hC, IOB + 32'h10})) setB[2] = 1;
    else if (wr) begin
      if (a < 32'h400) mem[int'(a >> 2)] = wd;
      else case (a)
        IOB:          mLed = wd[15:0];
        IOB + 32'h8:  cleared = 1;
        IOB + 32'hC:  mCmp = wd;
        IOB + 32'h10: clrB = wd[2:0];
        default: ;
      endcase
    end
    mCount = cleared ? 32'h0 : mCount + 1;
    mStatus = (mStatus & ~clrB) | setB;
    swHist.push_back(switches);
  endtask

  task automatic cycle(input logic [31:0] a, input logic [31:0] wd, input bit rd, input bit wr,
                       input bit hasWant, input logic [31:0] want, input string tag);
    logic [31:0] e;
    memAddress = a; writeDataMem = wd; memRead = rd; memWrite = wr;
    @(negedge clk);
    if (hasWant) checkVal(tag, readDataMem, want);
    if (rd && expRead(a, e)) checkVal({tag, ".model"}, readDataMem, e);
    if (!rd) checkVal({tag, ".rdIdle"}, readDataMem, 32'h0);
    checkVal({tag, ".leds"}, {16'h0, leds}, {16'h0, mLed});
    checkVal({tag, ".irq"}, {31'h0, timerIrq}, {31'h0, mStatus[0]});
    @(posedge clk);
    modelEdge(a, wd, rd, wr);
    #1;
  endtask

  task automatic st(input logic [31:0] a, input logic [31:0] wd);
    cycle(a, wd, 1'b0, 1'b1, 1'b0, 32'h0, "st");
  endtask

  task automatic ld(input logic [31:0] a, input logic [31:0] want, input string tag);
    cycle(a, 32'h0, 1'b1, 1'b0, 1'b1, want, tag);
  endtask

  task automatic idle();
    cycle(32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, "idle");
  endtask

  initial begin
    logic [31:0] a, wd;
    modelReset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    checkVal("rst.leds", {16'h0, leds}, 32'h0);
    checkVal("rst.irq", {31'h0, timerIrq}, 32'h0);
    checkVal("rst.rd", readDataMem, 32'h0);
    rst = 1'b1;
    @(posedge clk);
    modelEdge(0, 0, 0, 0);
    #1;
    st(32'h40, 32'hDEADBEEF);
    ld(32'h40, 32'hDEADBEEF, "ram.ld40");
    cycle(32'h44, 32'h0, 1'b1, 1'b0, 1'b0, 32'h0, "ram.ld44");
    ld(IOB + 32'h10, 32'h0, "noX.status");
    st(IOB, 32'h0001A5A5);
    ld(IOB, 32'h0000A5A5, "led.rd");
    switches = 16'h00F0;
    ld(IOB + 32'h4, 32'h0, "sw.edge0");
    ld(IOB + 32'h4, 32'h0, "sw.edge1");
    ld(IOB + 32'h4, 32'h000000F0, "sw.edge2");
    st(IOB + 32'hC, 32'd5);
    st(IOB + 32'h8, 32'h0);
    ld(IOB + 32'h8, 32'h0, "cnt.cleared");
    repeat (4) idle();
    ld(IOB + 32'h10, 32'h0, "tmr.pre");
    ld(IOB + 32'h10, 32'h1, "tmr.hit");
    st(IOB + 32'h10, 32'h1);
    ld(IOB + 32'h10, 32'h0, "tmr.w1c");
    st(IOB + 32'h8, 32'h0);
    repeat (5) idle();
    st(IOB + 32'h10, 32'h1);
    ld(IOB + 32'h10, 32'h1, "tmr.collide");
    st(IOB + 32'hC, 32'h0);
    st(IOB + 32'h10, 32'h7);
    st(32'h42, 32'h12345678);
    ld(32'h40, 32'hDEADBEEF, "mis.ramKept");
    ld(IOB + 32'h10, 32'h2, "mis.status");
    ld(32'h8000, 32'h0, "unm.rd");
    ld(IOB + 32'h10, 32'h6, "unm.status");
    ld(32'h41, 32'h0, "mis.rd");
    cycle(32'h40, 32'hCAFEF00D, 1'b1, 1'b1, 1'b1, 32'hDEADBEEF, "rw.old");
    ld(32'h40, 32'hCAFEF00D, "rw.new");
    st(32'h3FC, 32'h0BADC0DE);
    ld(32'h3FC, 32'h0BADC0DE, "ram.top");
    ld(32'h400, 32'h0, "ram.past");
    st(IOB, 32'hFFFF);
    st(IOB + 32'h8, 32'h0);
    repeat (32) idle();
    ld(IOB + 32'h8, 32'h20, "cnt.x20");
    checkVal("pre.leds", {16'h0, leds}, 32'h0000FFFF);
    rst = 1'b0;
    memRead = 1'b1; memWrite = 1'b0; memAddress = IOB + 32'h8;
    #1;
    checkVal("arst.leds", {16'h0, leds}, 32'h0);
    checkVal("arst.irq", {31'h0, timerIrq}, 32'h0);
    checkVal("arst.count", readDataMem, 32'h0);
    memRead = 1'b0; memWrite = 1'b1; memAddress = 32'h40; writeDataMem = 32'h11111111;
    modelReset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    memWrite = 1'b0;
    rst = 1'b1;
    @(posedge clk);
    modelEdge(0, 0, 0, 0);
    #1;
    ld(32'h40, 32'hCAFEF00D, "arst.storeDropped");
    for (int i = 0; i < 400; i++) begin
      case ($urandom_range(0, 5))
        0, 1: a = 32'($urandom_range(0, 15)) * 4;
        2, 3: a = IOB + 32'($urandom_range(0, 4)) * 4;
        4:    a = (32'($urandom_range(0, 15)) * 4) | 32'($urandom_range(1, 3));
        default: a = ($urandom_range(0, 1) != 0) ? 32'h400 : IOB + 32'h14;
      endcase
      wd = (a == IOB + 32'hC) ? 32'($urandom_range(0, 40)) : $urandom;
      if ($urandom_range(0, 9) == 0) switches = 16'($urandom);
      cycle(a, wd, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 2) == 0), 1'b0, 32'h0, "rand");
    end
    $display("== %0d vectors applied, %0d miscompares ==", nVec, nBad);
    $finish;
  end
endmodule
